sym_decoder: RTL and testbench
==============================

Name: sym_decoder

Overview:
- Receive-side decoder for the team's 2-bit differential symbol link. The transmit-side Mealy encoder FSM emits one 2-bit symbol per clock; this block recovers the {a,b} data pairs.
- Recovery is differential decoding: decoded = symbol XOR previous symbol.
- Frames are delimited by a sync run, a fixed-length payload and one parity symbol.
- Sits directly on the symbol bus. Delivers decoded pairs, frame markers, frame status and an error count to downstream logic.

Parameters:
SYNC_SYM, 2'b11, raw symbol value forming the sync run
SYNC_LEN, 4, consecutive SYNC_SYM symbols required to arm (range 2..15)
FRAME_LEN, 4, payload symbols per frame (range 1..255)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous active-low reset; reset applies at a clk edge when rst==0
in_valid  input  1  symbol on y accepted this cycle when 1
y  input  2  raw received symbol
out_valid  output  1  decoded payload pair valid (one-cycle pulse per payload symbol)
a  output  1  decoded bit 1 (decoded[1])
b  output  1  decoded bit 0 (decoded[0])
frame_start  output  1  qualifies the first payload pair of a frame
frame_end  output  1  qualifies the last payload pair of a frame
frame_ok  output  1  one-cycle pulse: parity symbol matched
err  output  1  one-cycle pulse: parity symbol mismatched
locked  output  1  1 in ARMED, DATA or CHECK
err_count  output  8  saturating count of parity errors

Behaviour:
- All outputs are registered. A result appears one clk after the accepting edge, which is a latency of 1.
- Reset (rst==0 at an edge):
  - state=HUNT, prev=2'b00, run=0, idx=0, par=2'b00, err_count=0.
  - All outputs 0.
  - Reset mid-frame discards the frame with no err pulse.
- in_valid==0 freezes state, prev, run, idx and par. Pulse outputs go to 0 on the next edge.
- Differential decode: decoded = y ^ prev. prev <= y on every accepted symbol in every state.
- States:
  - HUNT:
    - Accepted y==SYNC_SYM: run <= run+1 (saturates at SYNC_LEN).
    - Accepted other symbol: run <= 0.
    - When the accepted symbol makes run reach SYNC_LEN: go to ARMED.
  - ARMED:
    - y==SYNC_SYM: stay in ARMED (sync run may be arbitrarily long).
    - Any other symbol is payload #1: out_valid=1, frame_start=1, par <= decoded, idx <= 1.
      - If FRAME_LEN==1: also frame_end=1 and go to CHECK.
      - Otherwise go to DATA.
  - DATA:
    - Every accepted symbol is payload, including SYNC_SYM values; there is no escaping.
    - Each one gives out_valid=1, par <= par ^ decoded, idx <= idx+1.
    - The symbol with idx+1==FRAME_LEN: frame_end=1, go to CHECK.
  - CHECK:
    - The next accepted symbol is parity and is not emitted on out_valid.
    - decoded == par: frame_ok=1, go to ARMED.
    - decoded != par: err=1, err_count <= err_count+1 (holds at 255), go to HUNT, run <= 0.
- Payload constraint: the first payload symbol must differ from SYNC_SYM. This is a transmitter obligation; the decoder treats such a symbol as extended sync.
- locked is registered and mirrors the state after the edge.
- There are no simultaneous-event conflicts: one symbol per edge, and each state has exactly one transition per accepted symbol.

Decomposition:
- Package sym_pkg holds:
  - state enum HUNT/ARMED/DATA/CHECK (2-bit encoding)
  - default constants for SYNC_SYM, SYNC_LEN, FRAME_LEN
  - ERR_MAX=8'hFF
- One sub-module, sym_diff_dec: prev register plus XOR, with in_valid and rst inputs, outputting decoded. The FSM, counters, parity accumulator and output registers stay in sym_decoder.

Test Plan:
- Default parameters. After reset, send y=11,11,11,11, then payload 01,01,10,00, then parity 11.
  - Required: a,b = 10,00,11,10 with out_valid on 4 consecutive cycles.
  - frame_start on the first pair, frame_end on the fourth.
  - frame_ok=1 one cycle after parity; err_count=0; locked stays 1.
- Same stream with parity 00 -> err=1, err_count=1, locked=0 after the edge, no frame_ok.
- Sync run 11,11,11,01,11,11,11,11 -> locked rises only after the 8th symbol. The 01 clears run, so no arm after the 3rd 11.
- A valid frame with in_valid deasserted for 3 cycles between payload symbols 2 and 3 -> identical decoded values and frame_ok; no out_valid during the gap.
- rst=0 asserted for one edge while in DATA after 2 payload symbols -> all outputs 0, err_count=0. The next frame needs a full 4-symbol sync run.
- Force 256 parity errors -> err_count saturates at 255 and err still pulses each time.

Source files
------------

// File: rtl/sym_pkg.sv
// Shared definitions for the 2-bit differential symbol link receiver.
//   state_t      : decoder FSM states (2-bit encoding)
//   *_D          : default framing parameters
//   ERR_MAX      : saturation value of the parity error counter
package sym_pkg;

  typedef enum logic [1:0] {
    HUNT  = 2'd0,
    ARMED = 2'd1,
    DATA  = 2'd2,
    CHECK = 2'd3
  } state_t;

  localparam logic [1:0] SYNC_SYM_D  = 2'b11;
  localparam int unsigned SYNC_LEN_D  = 4;
  localparam int unsigned FRAME_LEN_D = 4;
  localparam logic [7:0] ERR_MAX     = 8'hFF;

endpackage

// File: rtl/sym_diff_dec.sv
// Differential symbol decoder: decoded = y ^ previous accepted symbol.
//   clk, rst     : clock, synchronous active-low reset
//   in_valid     : y is accepted this cycle (prev updates only then)
//   y            : raw received symbol
//   decoded      : combinational decode of the current y
module sym_diff_dec (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] y,
  output logic [1:0] decoded
);

  logic [1:0] prev;

  always_ff @(posedge clk) begin
    if (!rst)          prev <= 2'b00;
    else if (in_valid) prev <= y;
  end

  assign decoded = y ^ prev;

endmodule

// File: rtl/sym_decoder.sv
// Receive-side frame decoder for the 2-bit differential symbol link.
// Hunts for a sync run, emits FRAME_LEN decoded payload pairs, then checks
// one parity symbol against the XOR of the decoded payload.
//   clk, rst               : clock, synchronous active-low reset
//   in_valid, y            : symbol input
//   out_valid, a, b        : decoded payload pair (a = bit 1, b = bit 0)
//   frame_start, frame_end : qualify first / last payload pair of a frame
//   frame_ok, err          : parity result pulses
//   locked                 : state is ARMED, DATA or CHECK
//   err_count              : saturating parity error count
// All outputs are registered (latency 1 from the accepting edge).
module sym_decoder
  import sym_pkg::*;
#(
  parameter logic [1:0]  SYNC_SYM  = SYNC_SYM_D,
  parameter int unsigned SYNC_LEN  = SYNC_LEN_D,
  parameter int unsigned FRAME_LEN = FRAME_LEN_D
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  input  logic [1:0] y,
  output logic       out_valid,
  output logic       a,
  output logic       b,
  output logic       frame_start,
  output logic       frame_end,
  output logic       frame_ok,
  output logic       err,
  output logic       locked,
  output logic [7:0] err_count
);

  localparam logic [3:0] RUN_SYNC = 4'(SYNC_LEN);
  localparam logic [3:0] RUN_LAST = 4'(SYNC_LEN - 1);
  localparam logic [8:0] IDX_LAST = 9'(FRAME_LEN);

  state_t     state, state_n;
  logic [3:0] run, run_n;
  logic [7:0] idx, idx_n;
  logic [1:0] par, par_n;
  logic [1:0] dec, ab_n;
  logic       ov_n, fs_n, fe_n, ok_n, err_n;
  logic [7:0] ec_n;

  sym_diff_dec u_diff (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .y        (y),
    .decoded  (dec)
  );

  always_comb begin
    state_n = state;
    run_n   = run;
    idx_n   = idx;
    par_n   = par;
    ov_n    = 1'b0;
    fs_n    = 1'b0;
    fe_n    = 1'b0;
    ok_n    = 1'b0;
    err_n   = 1'b0;
    ab_n    = 2'b00;
    ec_n    = err_count;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          if (y == SYNC_SYM) begin
            // run saturates at SYNC_LEN; reaching it arms the decoder
            if (run >= RUN_LAST) begin
              run_n   = RUN_SYNC;
              state_n = ARMED;
            end else begin
              run_n = run + 4'd1;
            end
          end else begin
            run_n = 4'd0;
          end
        end
        ARMED: begin
          // further sync symbols just extend the run
          if (y != SYNC_SYM) begin
            ov_n  = 1'b1;
            fs_n  = 1'b1;
            ab_n  = dec;
            par_n = dec;
            idx_n = 8'd1;
            if (FRAME_LEN == 1) begin
              fe_n    = 1'b1;
              state_n = CHECK;
            end else begin
              state_n = DATA;
            end
          end
        end
        DATA: begin
          // no escaping: sync-valued symbols are payload here
          ov_n  = 1'b1;
          ab_n  = dec;
          par_n = par ^ dec;
          idx_n = idx + 8'd1;
          if ({1'b0, idx} + 9'd1 == IDX_LAST) begin
            fe_n    = 1'b1;
            state_n = CHECK;
          end
        end
        CHECK: begin
          if (dec == par) begin
            ok_n    = 1'b1;
            state_n = ARMED;
          end else begin
            err_n   = 1'b1;
            if (err_count != ERR_MAX) ec_n = err_count + 8'd1;
            run_n   = 4'd0;
            state_n = HUNT;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= HUNT;
      run         <= 4'd0;
      idx         <= 8'd0;
      par         <= 2'b00;
      out_valid   <= 1'b0;
      a           <= 1'b0;
      b           <= 1'b0;
      frame_start <= 1'b0;
      frame_end   <= 1'b0;
      frame_ok    <= 1'b0;
      err         <= 1'b0;
      locked      <= 1'b0;
      err_count   <= 8'd0;
    end else begin
      state       <= state_n;
      run         <= run_n;
      idx         <= idx_n;
      par         <= par_n;
      out_valid   <= ov_n;
      a           <= ab_n[1];
      b           <= ab_n[0];
      frame_start <= fs_n;
      frame_end   <= fe_n;
      frame_ok    <= ok_n;
      err         <= err_n;
      locked      <= (state_n != HUNT);
      err_count   <= ec_n;
    end
  end

endmodule

// File: tb/tb_sym_decoder.sv
// Scoreboard bench for sym_decoder with default parameters.
module tb_sym_decoder;

  typedef struct packed {
    logic       ov;
    logic [1:0] ab;
    logic       fs;
    logic       fe;
    logic       ok;
    logic       er;
    logic       lk;
    logic [7:0] ec;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       in_valid = 1'b0;
  logic [1:0] y = 2'b00;
  logic       out_valid, a, b, frame_start, frame_end, frame_ok, err, locked;
  logic [7:0] err_count;

  int   n_chk = 0;
  int   n_bad = 0;
  logic [7:0] ec_exp = 8'd0;
  exp_t sb[$];

  sym_decoder dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .y(y),
    .out_valid(out_valid), .a(a), .b(b),
    .frame_start(frame_start), .frame_end(frame_end),
    .frame_ok(frame_ok), .err(err), .locked(locked), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Drive one cycle, push the expectation, and pop/compare it #1 after the edge.
  task automatic cyc(input logic r, input logic v, input logic [1:0] yy, input exp_t e);
    exp_t x;
    rst = r; in_valid = v; y = yy;
    sb.push_back(e);
    @(posedge clk);
    #1;
    x = sb.pop_front();
    chk("out_valid",   8'(out_valid),   8'(x.ov));
    if (x.ov) chk("ab", 8'({a, b}), 8'(x.ab));
    chk("frame_start", 8'(frame_start), 8'(x.fs));
    chk("frame_end",   8'(frame_end),   8'(x.fe));
    chk("frame_ok",    8'(frame_ok),    8'(x.ok));
    chk("err",         8'(err),         8'(x.er));
    chk("locked",      8'(locked),      8'(x.lk));
    chk("err_count",   err_count,       x.ec);
  endtask

  function automatic exp_t mk(logic ov, logic [1:0] ab, logic fs, logic fe,
                              logic ok, logic er, logic lk);
    exp_t e;
    e = '{ov: ov, ab: ab, fs: fs, fe: fe, ok: ok, er: er, lk: lk, ec: ec_exp};
    return e;
  endfunction

  task automatic snd(input logic [1:0] yy, input exp_t e);
    cyc(1'b1, 1'b1, yy, e);
  endtask

  task automatic idle(input logic lk);
    cyc(1'b1, 1'b0, 2'b11, mk(0, 2'b00, 0, 0, 0, 0, lk));
  endtask

  task automatic do_reset();
    ec_exp = 8'd0;
    cyc(1'b0, 1'b1, 2'b10, mk(0, 2'b00, 0, 0, 0, 0, 0));
  endtask

  // Four sync symbols; prev ends at 11.
  task automatic sync4(input logic armed);
    for (int i = 0; i < 4; i++)
      snd(2'b11, mk(0, 2'b00, 0, 0, 0, 0, armed || (i == 3)));
  endtask

  // Payload 01,01,10,00 after prev=11 decodes to 10,00,11,10 (parity 11).
  task automatic frame(input logic good, input logic gap);
    snd(2'b01, mk(1, 2'b10, 1, 0, 0, 0, 1));
    snd(2'b01, mk(1, 2'b00, 0, 0, 0, 0, 1));
    if (gap) for (int i = 0; i < 3; i++) idle(1'b1);
    snd(2'b10, mk(1, 2'b11, 0, 0, 0, 0, 1));
    snd(2'b00, mk(1, 2'b10, 0, 1, 0, 0, 1));
    if (good) begin
      snd(2'b11, mk(0, 2'b00, 0, 0, 1, 0, 1));   // 11^00 = 11 matches
    end else begin
      if (ec_exp != 8'hFF) ec_exp = ec_exp + 8'd1;
      snd(2'b00, mk(0, 2'b00, 0, 0, 0, 1, 0));   // 00^00 = 00 mismatches
    end
  endtask

  initial begin
    // reset state
    do_reset();
    do_reset();

    // good frame
    sync4(1'b0);
    frame(1'b1, 1'b0);

    // bad parity: prev=11 after good parity, still ARMED during sync
    sync4(1'b1);
    frame(1'b0, 1'b0);

    // broken sync run: 11,11,11,01 then 4x 11
    for (int i = 0; i < 3; i++) snd(2'b11, mk(0, 2'b00, 0, 0, 0, 0, 0));
    snd(2'b01, mk(0, 2'b00, 0, 0, 0, 0, 0));
    sync4(1'b0);

    // frame with 3-cycle in_valid gap (y=11 during gap must not update prev)
    frame(1'b1, 1'b1);

    // reset mid-frame in DATA
    snd(2'b01, mk(1, 2'b10, 1, 0, 0, 0, 1));
    snd(2'b01, mk(1, 2'b00, 0, 0, 0, 0, 1));
    do_reset();
    for (int i = 0; i < 3; i++) snd(2'b11, mk(0, 2'b00, 0, 0, 0, 0, 0));
    snd(2'b01, mk(0, 2'b00, 0, 0, 0, 0, 0));   // not armed after only 3 syncs
    sync4(1'b0);
    frame(1'b1, 1'b0);

    // 256 parity errors -> saturation at 255
    for (int k = 0; k < 256; k++) begin
      sync4(k == 0);
      frame(1'b0, 1'b0);
    end
    chk("err_count_sat", err_count, 8'hFF);
    idle(1'b0);

    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL scoreboard_left got=%0d exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule
